// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and helpers for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ARG     = 3'd2,
        EXEC    = 3'd3,
        REPLY   = 3'd4,
        DISCARD = 3'd5
    } state_e;

    localparam logic [7:0]  ASCII_CR = 8'h0D;
    localparam logic [7:0]  ASCII_LF = 8'h0A;
    localparam logic [7:0]  ASCII_T  = 8'h54;
    localparam logic [7:0]  ASCII_S  = 8'h53;
    localparam logic [7:0]  ASCII_R  = 8'h52;
    localparam logic [7:0]  ASCII_0  = 8'h30;
    localparam logic [7:0]  ASCII_1  = 8'h31;
    localparam logic [15:0] ASCII_OK = 16'h4F4B;
    localparam logic [15:0] ASCII_ER = 16'h4552;

    localparam int REPLY_LEN = 4;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

endpackage

// File: rtl/uart_cmd_reply.sv
// Reply serializer: holds a fixed-length reply and hands it out one byte per
// accepted transfer on a valid/ready style transmit interface.
module uart_cmd_reply
    import uart_cmd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [REPLY_LEN*8-1:0] bytes,
    input  logic                   tx_ready,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    output logic                   last
);

    localparam int IW = $clog2(REPLY_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(REPLY_LEN - 1);

    logic [REPLY_LEN*8-1:0] buf_r;
    logic [REPLY_LEN*8-1:0] buf_n;
    logic [IW-1:0]          idx_r;
    logic [IW-1:0]          idx_n;
    logic                   send_r;
    logic                   send_n;
    logic [7:0]             data_r;
    logic [7:0]             data_n;

    // Next buffer/index/output byte; tx_data is pre-registered so it stays stable under backpressure.
    always_comb begin
        buf_n  = buf_r;
        idx_n  = idx_r;
        send_n = send_r;
        data_n = data_r;
        if (load) begin
            buf_n  = bytes;
            idx_n  = '0;
            send_n = 1'b1;
            data_n = bytes[7:0];
        end else if (send_r && tx_ready) begin
            if (idx_r == LAST_IDX) begin
                send_n = 1'b0;
                idx_n  = '0;
                data_n = 8'h00;
            end else begin
                idx_n  = idx_r + 1'b1;
                data_n = buf_r[{idx_n, 3'b000} +: 8];
            end
        end else begin
            send_n = send_r;
        end
    end

    // Serializer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_r  <= '0;
            idx_r  <= '0;
            send_r <= 1'b0;
            data_r <= 8'h00;
        end else begin
            buf_r  <= buf_n;
            idx_r  <= idx_n;
            send_r <= send_n;
            data_r <= data_n;
        end
    end

    assign tx_send = send_r;
    assign tx_data = data_r;
    assign last    = send_r && (idx_r == LAST_IDX);

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented LED command parser between a UART receiver and transmitter.
// Define UART_CMD_DROPCNT_EN to add the saturating drop_count output.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NLED   = 4,
    parameter int MAXARG = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    input  logic            tx_ready,
    output logic            tx_send,
    output logic [7:0]      tx_data,
    output logic [NLED-1:0] led
`ifdef UART_CMD_DROPCNT_EN
    ,
    output logic [7:0]      drop_count
`endif
);

    localparam int ACW  = $clog2(MAXARG + 1);
    localparam int ABUF = (MAXARG < 2) ? 2 : MAXARG;

    state_e                 state_r;
    state_e                 state_n;
    logic [7:0]             cmd_r;
    logic [7:0]             cmd_n;
    logic [ABUF*8-1:0]      arg_r;
    logic [ABUF*8-1:0]      arg_n;
    logic [ACW-1:0]         argcnt_r;
    logic [ACW-1:0]         argcnt_n;
    logic                   err_r;
    logic                   err_n;
    logic [NLED-1:0]        led_r;
    logic [NLED-1:0]        led_n;

    logic                   load_s;
    logic [REPLY_LEN*8-1:0] reply_s;
    logic                   tx_send_s;
    logic [7:0]             tx_data_s;
    logic                   last_s;
    logic                   done_s;
    logic [7:0]             arg0_s;
    logic [7:0]             arg1_s;
    logic                   digit_ok_s;
    logic [NLED-1:0]        mask_s;
    logic [7:0]             led_ext_s;
    logic [REPLY_LEN*8-1:0] ok_s;
    logic [REPLY_LEN*8-1:0] er_s;

    // Argument decode shared by the EXEC cases.
    always_comb begin
        arg0_s     = arg_r[7:0];
        arg1_s     = arg_r[15:8];
        digit_ok_s = (arg0_s >= ASCII_0) && (arg0_s < (ASCII_0 + 8'(NLED)));
        mask_s     = NLED'(1) << arg0_s[2:0];
        led_ext_s  = '0;
        led_ext_s[NLED-1:0] = led_r;
        done_s     = tx_send_s && tx_ready && last_s;
        ok_s       = {ASCII_LF, ASCII_CR, ASCII_OK[7:0], ASCII_OK[15:8]};
        er_s       = {ASCII_LF, ASCII_CR, ASCII_ER[7:0], ASCII_ER[15:8]};
    end

    // Next-state, argument capture, LED update and reply selection.
    always_comb begin
        state_n  = state_r;
        cmd_n    = cmd_r;
        arg_n    = arg_r;
        argcnt_n = argcnt_r;
        err_n    = err_r;
        led_n    = led_r;
        load_s   = 1'b0;
        reply_s  = er_s;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
                        state_n = IDLE;
                    end else if (rx_data == ASCII_T || rx_data == ASCII_S || rx_data == ASCII_R) begin
                        cmd_n    = rx_data;
                        argcnt_n = '0;
                        arg_n    = '0;
                        state_n  = CMD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            CMD, ARG: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_CR) begin
                        state_n = EXEC;
                    end else if (argcnt_r < ACW'(MAXARG)) begin
                        for (int i = 0; i < MAXARG; i++) begin
                            arg_n[i*8 +: 8] = (argcnt_r == ACW'(i)) ? rx_data : arg_r[i*8 +: 8];
                        end
                        argcnt_n = argcnt_r + 1'b1;
                        state_n  = ARG;
                    end else begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            DISCARD: begin
                if (rx_valid && rx_data == ASCII_CR) begin
                    state_n = EXEC;
                end else begin
                    state_n = DISCARD;
                end
            end
            EXEC: begin
                load_s  = 1'b1;
                state_n = REPLY;
                if (!err_r) begin
                    case (cmd_r)
                        ASCII_T: begin
                            if (argcnt_r == ACW'(1) && digit_ok_s) begin
                                led_n   = led_r ^ mask_s;
                                reply_s = ok_s;
                            end else begin
                                reply_s = er_s;
                            end
                        end
                        ASCII_S: begin
                            // Two arguments are unreachable when MAXARG < 2, hence the explicit guard.
                            if ((MAXARG >= 2) && argcnt_r == ACW'(2) && digit_ok_s &&
                                (arg1_s == ASCII_0 || arg1_s == ASCII_1)) begin
                                led_n   = (arg1_s == ASCII_1) ? (led_r | mask_s) : (led_r & ~mask_s);
                                reply_s = ok_s;
                            end else begin
                                reply_s = er_s;
                            end
                        end
                        ASCII_R: begin
                            if (argcnt_r == '0) begin
                                reply_s = {ASCII_LF, ASCII_CR,
                                           hex_to_ascii(led_ext_s[3:0]),
                                           hex_to_ascii(led_ext_s[7:4])};
                            end else begin
                                reply_s = er_s;
                            end
                        end
                        default: reply_s = er_s;
                    endcase
                end else begin
                    reply_s = er_s;
                end
            end
            REPLY: begin
                if (done_s) begin
                    state_n  = IDLE;
                    err_n    = 1'b0;
                    argcnt_n = '0;
                    arg_n    = '0;
                    cmd_n    = 8'h00;
                end else begin
                    state_n = REPLY;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Parser state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cmd_r    <= 8'h00;
            arg_r    <= '0;
            argcnt_r <= '0;
            err_r    <= 1'b0;
            led_r    <= '0;
        end else begin
            state_r  <= state_n;
            cmd_r    <= cmd_n;
            arg_r    <= arg_n;
            argcnt_r <= argcnt_n;
            err_r    <= err_n;
            led_r    <= led_n;
        end
    end

    uart_cmd_reply u_reply (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .bytes    (reply_s),
        .tx_ready (tx_ready),
        .tx_send  (tx_send_s),
        .tx_data  (tx_data_s),
        .last     (last_s)
    );

    assign tx_send = tx_send_s;
    assign tx_data = tx_data_s;
    assign led     = led_r;

`ifdef UART_CMD_DROPCNT_EN
    logic [7:0] drop_r;

    // Count bytes ignored while a command is executing or replying.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_r <= 8'h00;
        end else if (rx_valid && (state_r == EXEC || state_r == REPLY) && drop_r != 8'hFF) begin
            drop_r <= drop_r + 8'd1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign drop_count = drop_r;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level reference model predicts
// reply bytes and LED state; a negedge monitor checks every transmitted byte.
module tb_uart_cmd_parser;

    localparam int NLED   = 4;
    localparam int MAXARG = 2;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_X = 8'h58;
    localparam logic [7:0] CH_0 = 8'h30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_ready = 1'b1;
    logic            tx_send;
    logic [7:0]      tx_data;
    logic [NLED-1:0] led;
`ifdef UART_CMD_DROPCNT_EN
    logic [7:0]      drop_count;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    int         led_m = 0;
    int         drops_exp = 0;
    bit         rnd_ready = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_parser #(.NLED(NLED), .MAXARG(MAXARG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .led      (led)
`ifdef UART_CMD_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: pop expected bytes on each transfer, verify data holds under backpressure.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && tx_send) begin
            if (hold_prev) check("tx_stable", tx_data, prev_data);
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx got=%0h expected=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e);
                end
            end
        end
        hold_prev = rst_n && tx_send && !tx_ready;
        prev_data = tx_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: one complete line (without its CR) -> reply bytes and LED state.
    function automatic void model_line(input logic [7:0] q[$]);
        string      hx = "0123456789ABCDEF";
        int         n  = q.size();
        logic [7:0] c  = q[0];
        int         d  = (n > 1) ? (int'(q[1]) - 'h30) : -1;
        bit         ok = 1'b0;
        if (n - 1 <= MAXARG) begin
            if (c == CH_T && n == 2 && d >= 0 && d < NLED) begin
                led_m = led_m ^ (1 << d);
                ok = 1'b1;
            end else if (c == CH_S && n == 3 && d >= 0 && d < NLED &&
                         (q[2] == 8'h30 || q[2] == 8'h31)) begin
                if (q[2] == 8'h31) led_m = led_m | (1 << d);
                else               led_m = led_m & ~(1 << d);
                ok = 1'b1;
            end else if (c == CH_R && n == 1) begin
                exp_q.push_back(hx[(led_m >> 4) & 15]);
                exp_q.push_back(hx[led_m & 15]);
                exp_q.push_back(CR);
                exp_q.push_back(LF);
                return;
            end
        end
        exp_q.push_back(ok ? 8'h4F : 8'h45);
        exp_q.push_back(ok ? 8'h4B : 8'h52);
        exp_q.push_back(CR);
        exp_q.push_back(LF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic set_line(input string s);
        line_q.delete();
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endtask

    task automatic send_cur();
        model_line(line_q);
        foreach (line_q[i]) send_byte(line_q[i]);
        send_byte(CR);
    endtask

    task automatic send_str(input string s);
        set_line(s);
        send_cur();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_led"}, int'(led), led_m);
    endtask

    task automatic check_drops(input string name);
`ifdef UART_CMD_DROPCNT_EN
        check(name, int'(drop_count), drops_exp);
`else
        name = name;
`endif
    endtask

    initial begin
        logic [7:0] b;
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("reset_tx_send", tx_send, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_led", int'(led), 0);
        check_drops("reset_drop");
        rst_n = 1'b1;
        tick();

        // LED update two cycles after CR, reply on four consecutive cycles.
        set_line("T2");
        model_line(line_q);
        foreach (line_q[i]) send_byte(line_q[i]);
        send_byte(CR);
        check("t2_led_early", int'(led), 0);
        tick();
        check("t2_led", int'(led), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_send_consec", tx_send, 1);
            tick();
        end
        check("t2_send_end", tx_send, 0);
        wait_idle("t2");

        send_str("S01");
        wait_idle("s01");
        send_str("R");
        wait_idle("r05");
        check("led_is_5", int'(led), 5);

        send_str("T9");
        wait_idle("t9");
        send_str("X");
        wait_idle("x");
        send_str("S0111");
        wait_idle("s0111");
        check("err_led_kept", int'(led), 5);

        // CR/LF in IDLE must produce nothing; the monitor flags any stray byte.
        send_byte(CR);
        send_byte(LF);
        send_byte(CR);
        repeat (6) tick();
        check("noise_no_send", tx_send, 0);
        send_str("R");
        wait_idle("noise_r");

        // Backpressure with a command injected during the reply.
        tx_ready = 1'b0;
        send_str("R");
        send_byte(CH_T);
        send_byte(CH_0);
        send_byte(CR);
        drops_exp += 3;
        repeat (7) tick();
        check("hold_send", tx_send, 1);
        tx_ready = 1'b1;
        wait_idle("hold");
        check_drops("hold_drop");

        // Byte arriving with the final reply transfer is dropped.
        send_str("T1");
        repeat (4) tick();
        send_byte(CH_X);
        drops_exp += 1;
        wait_idle("t1");
        send_str("R");
        wait_idle("r07");
        check_drops("final_drop");

        // Reset after the second reply byte aborts the reply.
        send_str("R");
        repeat (3) tick();
        check("rst_remaining", exp_q.size(), 2);
        rst_n = 1'b0;
        tick();
        check("rst_send", tx_send, 0);
        check("rst_led", int'(led), 0);
        rst_n = 1'b1;
        exp_q.delete();
        led_m = 0;
        drops_exp = 0;
        check_drops("rst_drop");
        send_str("R");
        wait_idle("r00");

        // Randomized command lines with random transmitter backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) send_byte(($urandom_range(0, 1) != 0) ? CR : LF);
            line_q.delete();
            case ($urandom_range(0, 6))
                0: begin line_q.push_back(CH_T); line_q.push_back(CH_0 + 8'($urandom_range(0, NLED - 1))); end
                1: begin line_q.push_back(CH_T); line_q.push_back(CH_0 + 8'($urandom_range(0, 9))); end
                2: begin
                    line_q.push_back(CH_S);
                    line_q.push_back(CH_0 + 8'($urandom_range(0, 5)));
                    line_q.push_back(CH_0 + 8'($urandom_range(0, 2)));
                end
                3: line_q.push_back(CH_R);
                4: begin line_q.push_back(CH_R); line_q.push_back(CH_0 + 8'($urandom_range(0, 9))); end
                5: begin
                    line_q.push_back(8'h41 + 8'($urandom_range(0, 25)));
                    repeat ($urandom_range(0, 3)) line_q.push_back(CH_0 + 8'($urandom_range(0, 9)));
                end
                default: begin
                    line_q.push_back(CH_S);
                    repeat (3) begin
                        b = CH_0 + 8'($urandom_range(0, 1));
                        line_q.push_back(b);
                    end
                end
            endcase
            send_cur();
            wait_idle("rand");
        end
        rnd_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        check_drops("end_drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
